auth_blk: RTL and testbench

AUTH_BLK -- requirements
Module: auth_blk

---
 rtl/auth_blk.sv | 175 +++++++++++++++++
 tb/tb_auth_blk.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/auth_blk.sv
// auth_blk: UART command receiver (8N1, LSB first) feeding a power-up
// authorization state machine. A 'g' command powers the rider platform up,
// and an 's' command requests a stop. Power drops once the rider has stepped off.
module auth_blk #(
    parameter int BAUD_DIV = 2604
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       RX,
    input  logic       rider_off,
    output logic [7:0] cmd,
    output logic       cmd_rdy,
    output logic       frm_err,
    output logic       pwr_up
);

    // Receiver states
    localparam logic [1:0] RX_IDLE  = 2'd0;
    localparam logic [1:0] RX_START = 2'd1;
    localparam logic [1:0] RX_DATA  = 2'd2;
    localparam logic [1:0] RX_STOP  = 2'd3;

    // Authorization states
    localparam logic [1:0] AUTH_OFF  = 2'd0;
    localparam logic [1:0] AUTH_PWR1 = 2'd1;
    localparam logic [1:0] AUTH_PWR2 = 2'd2;

    localparam logic [7:0] CMD_GO   = 8'h67;
    localparam logic [7:0] CMD_STOP = 8'h73;

    // The expiry cycle itself is part of the count, so the value reloaded
    // between bit samples is one less than the bit period.
    localparam logic [11:0] HALF_BIT   = 12'(BAUD_DIV / 2);
    localparam logic [11:0] FULL_RELOD = 12'(BAUD_DIV - 1);

    logic        r_rxMeta;
    logic        r_rxSync;
    logic        r_rxPrev;
    logic [1:0]  r_syncFill;
    logic [1:0]  r_rxState;
    logic [11:0] r_baudCnt;
    logic [2:0]  r_bitCnt;
    logic [7:0]  r_shift;
    logic [7:0]  r_cmd;
    logic        r_cmdRdy;
    logic        r_frmErr;
    logic [1:0]  r_authState;
    logic        r_pwrUp;

    logic        w_startEdge;
    logic        w_expire;
    logic        w_isGo;
    logic        w_isStop;
    logic [1:0]  w_authNext;

    // A start edge is only seen once the synchronizer holds real RX history,
    // so a line already low when reset releases does not count as a start bit.
    assign w_startEdge = r_rxPrev & ~r_rxSync;
    assign w_expire    = (r_baudCnt == 12'd0);
    assign w_isGo      = r_cmdRdy && (r_cmd == CMD_GO);
    assign w_isStop    = r_cmdRdy && (r_cmd == CMD_STOP);

    // Two-flop RX synchronizer plus previous-sample tracking for edge detection
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rxMeta   <= 1'b1;
            r_rxSync   <= 1'b1;
            r_rxPrev   <= 1'b0;
            r_syncFill <= 2'b00;
        end else begin
            r_rxMeta   <= RX;
            r_rxSync   <= r_rxMeta;
            r_syncFill <= {r_syncFill[0], 1'b1};
            r_rxPrev   <= r_syncFill[1] ? r_rxSync : 1'b0;
        end
    end

    // Frame receiver: start-bit qualify, eight data samples, then stop check
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rxState <= RX_IDLE;
            r_baudCnt <= 12'd0;
            r_bitCnt  <= 3'd0;
            r_shift   <= 8'h00;
            r_cmd     <= 8'h00;
            r_cmdRdy  <= 1'b0;
            r_frmErr  <= 1'b0;
        end else begin
            r_cmdRdy <= 1'b0;
            r_frmErr <= 1'b0;
            case (r_rxState)
                RX_IDLE: begin
                    if (w_startEdge) begin
                        r_rxState <= RX_START;
                        r_baudCnt <= HALF_BIT;
                    end
                end
                RX_START: begin
                    if (w_expire) begin
                        if (!r_rxSync) begin
                            r_rxState <= RX_DATA;
                            r_baudCnt <= FULL_RELOD;
                            r_bitCnt  <= 3'd0;
                        end else begin
                            r_rxState <= RX_IDLE;
                        end
                    end else begin
                        r_baudCnt <= r_baudCnt - 12'd1;
                    end
                end
                RX_DATA: begin
                    if (w_expire) begin
                        r_shift   <= {r_rxSync, r_shift[7:1]};
                        r_baudCnt <= FULL_RELOD;
                        r_bitCnt  <= r_bitCnt + 3'd1;
                        if (r_bitCnt == 3'd7) begin
                            r_rxState <= RX_STOP;
                        end
                    end else begin
                        r_baudCnt <= r_baudCnt - 12'd1;
                    end
                end
                RX_STOP: begin
                    if (w_expire) begin
                        if (r_rxSync) begin
                            r_cmd    <= r_shift;
                            r_cmdRdy <= 1'b1;
                        end else begin
                            r_frmErr <= 1'b1;
                        end
                        r_rxState <= RX_IDLE;
                    end else begin
                        r_baudCnt <= r_baudCnt - 12'd1;
                    end
                end
                default: r_rxState <= RX_IDLE;
            endcase
        end
    end

    // Authorization next-state: a command outranks rider_off in PWR2
    always_comb begin
        w_authNext = r_authState;
        case (r_authState)
            AUTH_OFF: begin
                if (w_isGo) w_authNext = AUTH_PWR1;
            end
            AUTH_PWR1: begin
                if (w_isStop) w_authNext = rider_off ? AUTH_OFF : AUTH_PWR2;
            end
            AUTH_PWR2: begin
                if (w_isGo)         w_authNext = AUTH_PWR1;
                else if (rider_off) w_authNext = AUTH_OFF;
            end
            default: w_authNext = AUTH_OFF;
        endcase
    end

    // Authorization state and registered power enable
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_authState <= AUTH_OFF;
            r_pwrUp     <= 1'b0;
        end else begin
            r_authState <= w_authNext;
            r_pwrUp     <= (w_authNext != AUTH_OFF);
        end
    end

    assign cmd     = r_cmd;
    assign cmd_rdy = r_cmdRdy;
    assign frm_err = r_frmErr;
    assign pwr_up  = r_pwrUp;

endmodule

// File: tb/tb_auth_blk.sv
// tb_auth_blk: drives UART frames into auth_blk and checks command capture,
// framing errors and power-up sequencing against a behavioural model.
module tb_auth_blk;

    localparam int B = 32;

    logic       clk;
    logic       rst_n;
    logic       RX;
    logic       rider_off;
    logic [7:0] cmd;
    logic       cmd_rdy;
    logic       frm_err;
    logic       pwr_up;

    int checks = 0;
    int failures = 0;

    // Reference model: 0 = off, 1 = rider commanded on, 2 = stop requested
    int         modelState = 0;
    logic [7:0] expCmd = 8'h00;

    // Observed pulse history
    int         cycle = 0;
    int         rdyCount = 0;
    int         errCount = 0;
    int         rdyCycle = 0;
    logic [7:0] rdyCmd = 8'h00;
    logic       pwrAtRdy = 1'b0;
    logic       pwrAfterRdy = 1'b0;
    bit         grabNext = 1'b0;

    auth_blk #(.BAUD_DIV(B)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .RX        (RX),
        .rider_off (rider_off),
        .cmd       (cmd),
        .cmd_rdy   (cmd_rdy),
        .frm_err   (frm_err),
        .pwr_up    (pwr_up)
    );

    // 10 ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Record output pulses on the falling edge, away from the active edge
    always @(negedge clk) begin
        cycle++;
        if (grabNext) begin
            pwrAfterRdy = pwr_up;
            grabNext = 1'b0;
        end
        if (cmd_rdy === 1'b1) begin
            rdyCount++;
            rdyCmd = cmd;
            rdyCycle = cycle;
            pwrAtRdy = pwr_up;
            grabNext = 1'b1;
        end
        if (frm_err === 1'b1) errCount++;
    end

    function automatic int nextState(input int st, input logic [7:0] c, input logic rider);
        case (st)
            0: return (c == 8'h67) ? 1 : 0;
            1: begin
                if (c == 8'h73) return rider ? 0 : 2;
                return 1;
            end
            default: begin
                if (c == 8'h67) return 1;
                return rider ? 0 : 2;
            end
        endcase
    endfunction

    task automatic holdRx(input logic v, input int n);
        RX = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic sendFrame(input logic [7:0] data, input logic stopBit);
        holdRx(1'b0, B);
        for (int i = 0; i < 8; i++) holdRx(data[i], B);
        holdRx(stopBit, B);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        RX = 1'b1;
        rider_off = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (cmd !== 8'h00) begin failures++; $display("[TB] FAIL reset_cmd: got %h expected 00", cmd); end
        checks++;
        if (cmd_rdy !== 1'b0) begin failures++; $display("[TB] FAIL reset_cmd_rdy: got %b expected 0", cmd_rdy); end
        checks++;
        if (frm_err !== 1'b0) begin failures++; $display("[TB] FAIL reset_frm_err: got %b expected 0", frm_err); end
        checks++;
        if (pwr_up !== 1'b0) begin failures++; $display("[TB] FAIL reset_pwr_up: got %b expected 0", pwr_up); end
        rst_n = 1'b1;
        modelState = 0;
        expCmd = 8'h00;
        holdRx(1'b1, 4);
    endtask

    task automatic test_power_on();
        int baseRdy;
        int startCycle;
        int lat;
        baseRdy = rdyCount;
        startCycle = cycle;
        sendFrame(8'h67, 1'b1);
        modelState = nextState(modelState, 8'h67, rider_off);
        expCmd = 8'h67;
        lat = rdyCycle - startCycle;
        checks++;
        if (rdyCount - baseRdy !== 1) begin failures++; $display("[TB] FAIL pwron_pulses: got %0d expected 1", rdyCount - baseRdy); end
        checks++;
        if (rdyCmd !== 8'h67) begin failures++; $display("[TB] FAIL pwron_cmd: got %h expected 67", rdyCmd); end
        checks++;
        if (lat < (B * 19) / 2 || lat > (B * 19) / 2 + 8) begin
            failures++;
            $display("[TB] FAIL pwron_latency: got %0d expected %0d..%0d", lat, (B * 19) / 2, (B * 19) / 2 + 8);
        end
        checks++;
        if (pwrAtRdy !== 1'b0) begin failures++; $display("[TB] FAIL pwron_pwr_at_rdy: got %b expected 0", pwrAtRdy); end
        checks++;
        if (pwrAfterRdy !== 1'b1) begin failures++; $display("[TB] FAIL pwron_pwr_after: got %b expected 1", pwrAfterRdy); end
    endtask

    task automatic test_stop_with_rider();
        rider_off = 1'b0;
        sendFrame(8'h73, 1'b1);
        modelState = nextState(modelState, 8'h73, 1'b0);
        expCmd = 8'h73;
        checks++;
        if (pwr_up !== (modelState != 0)) begin failures++; $display("[TB] FAIL stop_rider_on_pwr: got %b expected %b", pwr_up, modelState != 0); end
        @(posedge clk);
        #1;
        rider_off = 1'b1;
        @(negedge clk);
        checks++;
        if (pwr_up !== 1'b1) begin failures++; $display("[TB] FAIL rider_leave_hold: got %b expected 1", pwr_up); end
        @(negedge clk);
        modelState = (modelState == 2) ? 0 : modelState;
        checks++;
        if (pwr_up !== 1'b0) begin failures++; $display("[TB] FAIL rider_leave_drop: got %b expected 0", pwr_up); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_stop_rider_off();
        sendFrame(8'h67, 1'b1);
        modelState = nextState(modelState, 8'h67, rider_off);
        expCmd = 8'h67;
        checks++;
        if (pwr_up !== 1'b1) begin failures++; $display("[TB] FAIL go_rider_off_pwr: got %b expected 1", pwr_up); end
        rider_off = 1'b1;
        sendFrame(8'h73, 1'b1);
        modelState = nextState(modelState, 8'h73, 1'b1);
        expCmd = 8'h73;
        checks++;
        if (pwrAtRdy !== 1'b1) begin failures++; $display("[TB] FAIL stopoff_pwr_at_rdy: got %b expected 1", pwrAtRdy); end
        checks++;
        if (pwrAfterRdy !== (modelState != 0)) begin failures++; $display("[TB] FAIL stopoff_pwr_after: got %b expected %b", pwrAfterRdy, modelState != 0); end
    endtask

    task automatic test_frame_error();
        int baseRdy;
        int baseErr;
        rider_off = 1'b0;
        baseRdy = rdyCount;
        baseErr = errCount;
        sendFrame(8'h67, 1'b0);
        holdRx(1'b1, B);
        checks++;
        if (errCount - baseErr !== 1) begin failures++; $display("[TB] FAIL ferr_pulses: got %0d expected 1", errCount - baseErr); end
        checks++;
        if (rdyCount - baseRdy !== 0) begin failures++; $display("[TB] FAIL ferr_no_rdy: got %0d expected 0", rdyCount - baseRdy); end
        checks++;
        if (cmd !== expCmd) begin failures++; $display("[TB] FAIL ferr_cmd_hold: got %h expected %h", cmd, expCmd); end
        checks++;
        if (pwr_up !== (modelState != 0)) begin failures++; $display("[TB] FAIL ferr_pwr: got %b expected %b", pwr_up, modelState != 0); end
    endtask

    // Glitch shorter than half a bit must be rejected as a false start
    task automatic test_glitch();
        int baseRdy;
        int baseErr;
        baseRdy = rdyCount;
        baseErr = errCount;
        holdRx(1'b0, B / 3);
        holdRx(1'b1, 2 * B);
        checks++;
        if (rdyCount - baseRdy !== 0 || errCount - baseErr !== 0) begin
            failures++;
            $display("[TB] FAIL glitch_ignored: got rdy=%0d err=%0d expected 0 0", rdyCount - baseRdy, errCount - baseErr);
        end
        sendFrame(8'h67, 1'b1);
        modelState = nextState(modelState, 8'h67, rider_off);
        expCmd = 8'h67;
        checks++;
        if (cmd !== 8'h67 || rdyCount - baseRdy !== 1) begin
            failures++;
            $display("[TB] FAIL glitch_then_frame: got cmd=%h rdy=%0d expected 67 1", cmd, rdyCount - baseRdy);
        end
        checks++;
        if (pwr_up !== (modelState != 0)) begin failures++; $display("[TB] FAIL glitch_pwr: got %b expected %b", pwr_up, modelState != 0); end
    endtask

    task automatic test_back_to_back();
        int baseRdy;
        int firstCycle;
        int gap;
        logic [7:0] third;
        rider_off = 1'b0;
        baseRdy = rdyCount;
        sendFrame(8'h67, 1'b1);
        firstCycle = rdyCycle;
        modelState = nextState(modelState, 8'h67, 1'b0);
        sendFrame(8'h73, 1'b1);
        modelState = nextState(modelState, 8'h73, 1'b0);
        expCmd = 8'h73;
        gap = rdyCycle - firstCycle;
        checks++;
        if (rdyCount - baseRdy !== 2) begin failures++; $display("[TB] FAIL b2b_pulses: got %0d expected 2", rdyCount - baseRdy); end
        checks++;
        if (gap < 10 * B - 2 || gap > 10 * B + 2) begin failures++; $display("[TB] FAIL b2b_gap: got %0d expected %0d", gap, 10 * B); end
        checks++;
        if (cmd !== 8'h73) begin failures++; $display("[TB] FAIL b2b_cmd: got %h expected 73", cmd); end
        checks++;
        if (pwr_up !== (modelState != 0)) begin failures++; $display("[TB] FAIL b2b_pwr: got %b expected %b", pwr_up, modelState != 0); end
        // Third frame is cut short by reset during its data bits
        baseRdy = rdyCount;
        third = 8'h67;
        holdRx(1'b0, B);
        for (int i = 0; i < 4; i++) holdRx(third[i], B);
        rst_n = 1'b0;
        for (int i = 4; i < 8; i++) holdRx(third[i], B);
        holdRx(1'b1, B);
        modelState = 0;
        expCmd = 8'h00;
        checks++;
        if (pwr_up !== 1'b0) begin failures++; $display("[TB] FAIL midreset_pwr: got %b expected 0", pwr_up); end
        rst_n = 1'b1;
        holdRx(1'b1, 2 * B);
        checks++;
        if (rdyCount - baseRdy !== 0) begin failures++; $display("[TB] FAIL midreset_no_rdy: got %0d expected 0", rdyCount - baseRdy); end
        checks++;
        if (cmd !== expCmd) begin failures++; $display("[TB] FAIL midreset_cmd: got %h expected %h", cmd, expCmd); end
    endtask

    // Line held low across reset release, then high: no frame may appear
    task automatic test_reset_low_rx();
        int baseRdy;
        int baseErr;
        RX = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        modelState = 0;
        expCmd = 8'h00;
        baseRdy = rdyCount;
        baseErr = errCount;
        holdRx(1'b0, B / 2);
        holdRx(1'b1, 10 * B);
        checks++;
        if (rdyCount - baseRdy !== 0 || errCount - baseErr !== 0) begin
            failures++;
            $display("[TB] FAIL lowrx_no_start: got rdy=%0d err=%0d expected 0 0", rdyCount - baseRdy, errCount - baseErr);
        end
        sendFrame(8'h67, 1'b1);
        modelState = nextState(modelState, 8'h67, rider_off);
        expCmd = 8'h67;
        checks++;
        if (cmd !== 8'h67 || pwr_up !== (modelState != 0)) begin
            failures++;
            $display("[TB] FAIL lowrx_then_frame: got cmd=%h pwr=%b expected 67 %b", cmd, pwr_up, modelState != 0);
        end
    endtask

    task automatic test_random();
        int baseRdy;
        int baseErr;
        int pick;
        logic [7:0] data;
        logic good;
        logic rider;
        for (int n = 0; n < 20; n++) begin
            pick = $urandom_range(0, 3);
            data = (pick == 0) ? 8'h67 : (pick == 1) ? 8'h73 : 8'($urandom_range(0, 255));
            good = ($urandom_range(0, 4) != 0);
            rider = 1'($urandom_range(0, 1));
            rider_off = rider;
            holdRx(1'b1, 3);
            if (modelState == 2 && rider) modelState = 0;
            baseRdy = rdyCount;
            baseErr = errCount;
            sendFrame(data, good);
            holdRx(1'b1, B);
            if (good) begin
                modelState = nextState(modelState, data, rider);
                expCmd = data;
            end
            checks++;
            if (rdyCount - baseRdy !== (good ? 1 : 0) || errCount - baseErr !== (good ? 0 : 1)) begin
                failures++;
                $display("[TB] FAIL rand_pulses[%0d]: got rdy=%0d err=%0d expected good=%b", n, rdyCount - baseRdy, errCount - baseErr, good);
            end
            checks++;
            if (cmd !== expCmd) begin failures++; $display("[TB] FAIL rand_cmd[%0d]: got %h expected %h", n, cmd, expCmd); end
            checks++;
            if (pwr_up !== (modelState != 0)) begin
                failures++;
                $display("[TB] FAIL rand_pwr[%0d]: got %b expected %b (data=%h rider=%b)", n, pwr_up, modelState != 0, data, rider);
            end
        end
    endtask

    // Scenario sequence
    initial begin
        rst_n = 1'b0;
        RX = 1'b1;
        rider_off = 1'b0;
        test_reset();
        test_power_on();
        test_stop_with_rider();
        test_stop_rider_off();
        test_frame_error();
        test_glitch();
        test_back_to_back();
        test_reset_low_rx();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
